// File: rtl/bp_table_ctrl.sv
// Write-port controller for the branch predictor state/target tables: arbitrates execute updates
// against an invalidation sweep, gates prediction use and keeps saturating branch statistics.
module bp_table_ctrl #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned TABLE_BITS = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  BranchE_i,
  input  logic                  TakenE_i,
  input  logic                  MispredictE_i,
  input  logic [PC_WIDTH-1:0]   PCE_i,
  input  logic [PC_WIDTH-1:0]   PCTargetE_i,
  input  logic                  flushReq_i,
  input  logic                  statsClr_i,
  output logic [TABLE_BITS-1:0] rdIdx_o,
  input  logic [1:0]            rdState_i,
  output logic                  wrEn_o,
  output logic [TABLE_BITS-1:0] wrIdx_o,
  output logic [1:0]            wrState_o,
  output logic [PC_WIDTH-1:0]   wrTarget_o,
  output logic                  predEnable_o,
  output logic                  sweepDone_o,
  output logic [CNT_WIDTH-1:0]  brCount_o,
  output logic [CNT_WIDTH-1:0]  mispCount_o
);

  typedef enum logic [1:0] {StInit, StIdle, StSweep} state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  state_e                state_q;
  logic [TABLE_BITS-1:0] sp_q;
  logic                  pred_en_q;
  logic                  done_q;
  logic [CNT_WIDTH-1:0]  br_cnt_q;
  logic [CNT_WIDTH-1:0]  misp_cnt_q;
  logic [1:0]            upd_state;
  logic                  sweeping;

  assign rdIdx_o      = PCE_i[TABLE_BITS+1:2];
  assign sweeping     = (state_q != StIdle);
  assign predEnable_o = pred_en_q;
  assign sweepDone_o  = done_q;
  assign brCount_o    = br_cnt_q;
  assign mispCount_o  = misp_cnt_q;

  always_comb begin
    upd_state = rdState_i;
    if (TakenE_i) begin
      if (rdState_i != 2'b11) upd_state = rdState_i + 2'b01;
    end else begin
      if (rdState_i != 2'b00) upd_state = rdState_i - 2'b01;
    end
  end

  // Execute update owns the port; otherwise the sweep writes. Nothing writes while in reset.
  always_comb begin
    wrEn_o     = 1'b0;
    wrIdx_o    = sp_q;
    wrState_o  = 2'b01;
    wrTarget_o = '0;
    if (BranchE_i) begin
      wrEn_o     = rst_ni;
      wrIdx_o    = PCE_i[TABLE_BITS+1:2];
      wrState_o  = upd_state;
      wrTarget_o = PCTargetE_i;
    end else if (sweeping) begin
      wrEn_o = rst_ni;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StInit;
      sp_q      <= '0;
      pred_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StInit, StSweep: begin
          if (flushReq_i) begin
            sp_q <= '0;
          end else if (!BranchE_i) begin
            if (&sp_q) begin
              state_q   <= StIdle;
              sp_q      <= '0;
              pred_en_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              sp_q <= sp_q + 1'b1;
            end
          end
        end
        StIdle: begin
          if (flushReq_i) begin
            state_q   <= StSweep;
            sp_q      <= '0;
            pred_en_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StInit;
          sp_q      <= '0;
          pred_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else if (statsClr_i) begin
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else if (BranchE_i) begin
      if (br_cnt_q != CntMax) br_cnt_q <= br_cnt_q + 1'b1;
      if (MispredictE_i && (misp_cnt_q != CntMax)) misp_cnt_q <= misp_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed + randomized bench for bp_table_ctrl with a cycle-level reference model
// (TABLE_BITS=8, CNT_WIDTH=4 so counter saturation is reachable).
module tb_bp_table_ctrl;

  localparam int PW = 32;
  localparam int TB = 8;
  localparam int CW = 4;
  localparam int N = 1 << TB;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          BranchE_i, TakenE_i, MispredictE_i, flushReq_i, statsClr_i;
  logic [PW-1:0] PCE_i, PCTargetE_i, wrTarget_o;
  logic [TB-1:0] rdIdx_o, wrIdx_o;
  logic [1:0]    rdState_i, wrState_o;
  logic          wrEn_o, predEnable_o, sweepDone_o;
  logic [CW-1:0] brCount_o, mispCount_o;

  bp_table_ctrl #(.PC_WIDTH(PW), .TABLE_BITS(TB), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .BranchE_i(BranchE_i), .TakenE_i(TakenE_i),
    .MispredictE_i(MispredictE_i), .PCE_i(PCE_i), .PCTargetE_i(PCTargetE_i),
    .flushReq_i(flushReq_i), .statsClr_i(statsClr_i), .rdIdx_o(rdIdx_o),
    .rdState_i(rdState_i), .wrEn_o(wrEn_o), .wrIdx_o(wrIdx_o), .wrState_o(wrState_o),
    .wrTarget_o(wrTarget_o), .predEnable_o(predEnable_o), .sweepDone_o(sweepDone_o),
    .brCount_o(brCount_o), .mispCount_o(mispCount_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_sweeping;
  int m_ptr;
  bit m_done;
  int m_br;
  int m_misp;
  bit last_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sweeping = 1'b1;
    m_ptr = 0;
    m_done = 1'b0;
    m_br = 0;
    m_misp = 0;
  endtask

  task automatic check_outputs();
    bit exp_we;
    int s;
    exp_we = rst_ni && (BranchE_i || m_sweeping);
    chk("rd_idx", 32'(rdIdx_o), (PCE_i >> 2) % N);
    chk("wr_en", 32'(wrEn_o), 32'(exp_we));
    if (exp_we) begin
      if (BranchE_i) begin
        s = int'(rdState_i) + (TakenE_i ? 1 : -1);
        if (s > 3) s = 3;
        if (s < 0) s = 0;
        chk("wr_idx_exec", 32'(wrIdx_o), (PCE_i >> 2) % N);
        chk("wr_state_exec", 32'(wrState_o), 32'(s));
        chk("wr_target_exec", wrTarget_o, PCTargetE_i);
      end else begin
        chk("wr_idx_sweep", 32'(wrIdx_o), 32'(m_ptr));
        chk("wr_state_sweep", 32'(wrState_o), 32'd1);
        chk("wr_target_sweep", wrTarget_o, 32'd0);
      end
    end
    chk("pred_enable", 32'(predEnable_o), 32'(!m_sweeping && rst_ni));
    chk("sweep_done", 32'(sweepDone_o), 32'(m_done));
    chk("br_count", 32'(brCount_o), 32'(m_br));
    chk("misp_count", 32'(mispCount_o), 32'(m_misp));
    last_done = sweepDone_o;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (m_sweeping) begin
      if (flushReq_i) m_ptr = 0;
      else if (!BranchE_i) begin
        if (m_ptr == N - 1) begin
          m_sweeping = 1'b0;
          m_ptr = 0;
          m_done = 1'b1;
        end else m_ptr++;
      end
    end else if (flushReq_i) begin
      m_sweeping = 1'b1;
      m_ptr = 0;
    end
    if (statsClr_i) begin
      m_br = 0;
      m_misp = 0;
    end else if (BranchE_i) begin
      if (m_br < CMAX) m_br++;
      if (MispredictE_i && m_misp < CMAX) m_misp++;
    end
  endtask

  // Called at posedge+1: sample mid-cycle, then advance one edge.
  task automatic cycle();
    #3;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_exec(input bit br);
    BranchE_i = br;
    TakenE_i = 1'($urandom);
    MispredictE_i = 1'($urandom);
    PCE_i = $urandom;
    PCTargetE_i = $urandom;
    rdState_i = 2'($urandom);
  endtask

  task automatic idle_inputs();
    rand_exec(1'b0);
    flushReq_i = 1'b0;
    statsClr_i = 1'b0;
  endtask

  initial begin
    int i;
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_outputs();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Reset sweep: 256 writes, then first IDLE cycle with done pulse
    for (int k = 0; k < N; k++) begin
      idle_inputs();
      cycle();
    end
    idle_inputs();
    cycle();
    chk("done_after_reset_sweep", 32'(last_done), 32'd1);
    cycle();

    // Saturation corners in IDLE
    BranchE_i = 1'b1; PCE_i = 32'h100; PCTargetE_i = 32'h2000; rdState_i = 2'b11;
    TakenE_i = 1'b1; MispredictE_i = 1'b0;
    #1;
    chk("sat_idx", 32'(wrIdx_o), 32'h40);
    chk("sat_up", 32'(wrState_o), 32'd3);
    cycle();
    rdState_i = 2'b00; TakenE_i = 1'b0; MispredictE_i = 1'b1;
    #1;
    chk("sat_down", 32'(wrState_o), 32'd0);
    cycle();
    rdState_i = 2'b01; TakenE_i = 1'b1; PCTargetE_i = 32'hdead_beec;
    #1;
    chk("inc_state", 32'(wrState_o), 32'd2);
    chk("inc_target", wrTarget_o, 32'hdead_beec);
    cycle();

    // Random IDLE traffic
    for (int k = 0; k < 200; k++) begin
      idle_inputs();
      rand_exec(1'($urandom_range(0, 2) != 0));
      statsClr_i = ($urandom_range(0, 40) == 0);
      cycle();
    end

    // Counters: clear, 5 branches with 2 mispredicted, then saturate, then clear+branch
    idle_inputs(); statsClr_i = 1'b1; cycle();
    for (int k = 0; k < 5; k++) begin
      idle_inputs(); rand_exec(1'b1); MispredictE_i = (k < 2); cycle();
    end
    chk("br_count_5", 32'(brCount_o), 32'd5);
    chk("misp_count_2", 32'(mispCount_o), 32'd2);
    for (int k = 0; k < 12; k++) begin
      idle_inputs(); rand_exec(1'b1); MispredictE_i = 1'b1; cycle();
    end
    #3;
    chk("br_count_sat", 32'(brCount_o), 32'd15);
    #1;
    statsClr_i = 1'b1; BranchE_i = 1'b1; MispredictE_i = 1'b1;
    cycle();
    chk("clr_wins_br", 32'(brCount_o), 32'd0);
    chk("clr_wins_misp", 32'(mispCount_o), 32'd0);

    // Sweep arbitration: branches on sweep cycles 10..12 stretch the sweep to 259 cycles
    idle_inputs(); flushReq_i = 1'b1; cycle();
    i = 0;
    while (i < 400) begin
      idle_inputs();
      if (i >= 10 && i <= 12) rand_exec(1'b1);
      cycle();
      if (last_done) break;
      i++;
    end
    chk("arb_sweep_len", 32'(i), 32'd259);

    // Flush restart at sp=200
    idle_inputs(); flushReq_i = 1'b1; cycle();
    for (int k = 0; k < 200; k++) begin
      idle_inputs(); cycle();
    end
    idle_inputs(); flushReq_i = 1'b1; cycle();
    idle_inputs();
    #1;
    chk("restart_idx0", 32'(wrIdx_o), 32'd0);
    i = 0;
    while (i < 400) begin
      idle_inputs();
      cycle();
      if (last_done) break;
      i++;
    end
    chk("restart_sweep_len", 32'(i), 32'd256);

    // Async reset mid-sweep at sp=77
    idle_inputs(); flushReq_i = 1'b1; cycle();
    for (int k = 0; k < 77; k++) begin
      idle_inputs(); cycle();
    end
    idle_inputs();
    #1;
    chk("pre_reset_idx", 32'(wrIdx_o), 32'd77);
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("async_wr_en", 32'(wrEn_o), 32'd0);
    chk("async_pred", 32'(predEnable_o), 32'd0);
    chk("async_br", 32'(brCount_o), 32'd0);
    #1;
    rst_ni = 1'b1;
    #1;
    chk("post_reset_idx", 32'(wrIdx_o), 32'd0);
    @(posedge clk);
    model_edge();
    #1;
    // Full sweep with random interleaved branches
    i = 0;
    while (i < 600) begin
      idle_inputs();
      rand_exec(1'($urandom_range(0, 3) == 0));
      cycle();
      if (last_done) break;
      i++;
    end
    chk("final_sweep_done", 32'(last_done), 32'd1);
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
